fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Circular instruction buffer between the fetch unit and decode; it decouples fetch response timing from decode stalls.
- Accepts {inst, pc, seq_num} from fetch on a val/rdy handshake and presents entries in order to decode.
- On a squash it flushes every buffered entry, because all of them are younger than the squashing instruction.
- The F-side and D-side ports map one-to-one onto F__DIntf fields.

Parameters:
- p_depth, 4, number of entries; any integer >= 2, not required to be a power of two
- p_seq_num_bits, 5, width of the sequence number carried with each instruction

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- enq_val  input  1  fetch presents a valid instruction
- enq_rdy  output  1  queue can accept an instruction
- enq_inst  input  32  instruction word
- enq_pc  input  32  instruction address
- enq_seq_num  input  p_seq_num_bits  sequence number allocated by fetch
- deq_val  output  1  head entry valid toward decode
- deq_rdy  input  1  decode accepts the head entry
- deq_inst  output  32  head instruction word
- deq_pc  output  32  head pc
- deq_seq_num  output  p_seq_num_bits  head sequence number
- squash_val  input  1  squash notification, flush all entries
- count  output  $clog2(p_depth+1)  current occupancy, for tracing and perf counters

Behaviour:
- Transfers:
  - enq_xfer = enq_val & enq_rdy & !squash_val
  - deq_xfer = deq_val & deq_rdy
- Storage and pointers:
  - Storage: p_depth entries of {inst, pc, seq_num}.
  - Registered head and tail pointers, width $clog2(p_depth).
  - Registered count.
- Reset: head = 0, tail = 0, count = 0, so deq_val = 0, enq_rdy = 1, count = 0. Storage contents are not reset.
- enq_rdy = (count < p_depth). It depends only on registered state, with no combinational path from deq_rdy. A full queue therefore does not accept an enqueue even when a dequeue happens in the same cycle.
- deq_val = (count > 0) & !squash_val.
- deq_* outputs are driven from the head entry. Values are don't-care when deq_val = 0.
- Latency: an entry enqueued in cycle N is visible at deq in cycle N+1 at the earliest. There is no bypass.
- Enqueue: on enq_xfer, write the entry at tail; tail advances by 1.
- Dequeue: on deq_xfer, head advances by 1.
- Pointer wrap: when a pointer equals p_depth-1 and advances, it wraps to 0. This uses an explicit compare, not modulo arithmetic, so non-power-of-two depths work.
- Count update:
  - +1 on enq_xfer only
  - -1 on deq_xfer only
  - unchanged when both or neither occur
- Simultaneous enq_xfer and deq_xfer: allowed only when 0 < count < p_depth; both take effect and count is unchanged.
- Empty: deq_val = 0, head == tail.
- Full: enq_rdy = 0, head == tail. count disambiguates full from empty.
- Squash:
  - In the squash_val cycle, deq_val = 0 and the incoming enqueue is dropped (enq_xfer = 0).
  - enq_rdy is still driven from count, so fetch may see a handshake. Fetch drops its own response in that cycle, so this is safe.
  - Next cycle: head = 0, tail = 0, count = 0. Squash has priority over every other update.
- Reset mid-operation: identical to squash plus reset values; rst has priority over squash_val.
- Assertions (non-synthesis):
  - count never exceeds p_depth
  - no deq_xfer when count = 0
- Linetrace: show count plus the enq pc and deq pc when each transfers; show "X" in the squash cycle.

Decomposition:
- Shared package:
  - fetch-decode entry struct: inst[31:0], pc[31:0], seq_num[p_seq_num_bits-1:0]
  - a pointer-increment-with-wrap function
- Sub-module: a register-file storage array fdq_storage, with one write port and one combinational read port, parameterized by depth and entry width.
- Control (pointers, count, squash) stays in fetch_decode_queue.

Test Plan:
1. Reset, then enqueue pc 0x200 and 0x204 with deq_rdy = 0 → count = 2. Then raise deq_rdy → deq_pc 0x200 then 0x204 on consecutive cycles, seq_nums preserved.
2. Enqueue 4 entries (p_depth = 4) → enq_rdy = 0 with count = 4. A 5th enq_val is held off. One dequeue → enq_rdy = 1 next cycle.
3. count = 2, enq and deq in the same cycle → count stays 2 and order is preserved. Run 10 streaming entries at full rate across pointer wrap → output pcs 0x200..0x224 in order.
4. count = 3, assert squash_val with enq_val = 1 (pc 0x300) → deq_val = 0 that cycle. Next cycle count = 0, deq_val = 0, and 0x300 is never dequeued.
5. Squash while empty, with an enqueue of 0x400 in the following cycle → 0x400 dequeued with correct seq_num, count = 1 → 0.
6. rst asserted while count = 3 and squash_val = 1 → next cycle count = 0, enq_rdy = 1, deq_val = 0. Run with p_depth = 3 to check non-power-of-two wrap over 8 entries.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and helpers for the fetch-to-decode instruction queue.
package fetch_decode_queue_pkg;

    localparam int FDQ_INST_BITS    = 32;
    localparam int FDQ_PC_BITS      = 32;
    localparam int FDQ_SEQ_NUM_BITS = 5;

    // One buffered fetch response at the default sequence-number width.
    typedef struct packed {
        logic [FDQ_INST_BITS-1:0]    inst;
        logic [FDQ_PC_BITS-1:0]      pc;
        logic [FDQ_SEQ_NUM_BITS-1:0] seq_num;
    } fdq_entry_t;

    // Advance a ring pointer by one, wrapping at depth-1 by explicit compare
    // so that depths which are not a power of two wrap correctly.
    function automatic logic [31:0] fdq_ptr_incr(input logic [31:0] ptr,
                                                 input logic [31:0] depth);
        logic [31:0] nxt;
        if (ptr == (depth - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_chk.sv
// Occupancy invariants of the fetch-decode queue.
module fetch_decode_queue_chk #(
    parameter int p_depth = 4
) (
    input logic                       clk,
    input logic                       rst,
    input logic [$clog2(p_depth+1)-1:0] count,
    input logic                       deq_xfer
);

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        (32'(count) <= 32'(p_depth)));

    a_no_deq_empty: assert property (@(posedge clk) disable iff (rst)
        (deq_xfer |-> (count != {($clog2(p_depth+1)){1'b0}})));

endmodule

// File: rtl/fetch_decode_queue_storage.sv
// Register-file storage for the queue: one write port, one combinational read port.
module fdq_storage #(
    parameter int p_depth = 4,
    parameter int p_width = 69
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(p_depth)-1:0] wr_addr,
    input  logic [p_width-1:0]         wr_data,
    input  logic [$clog2(p_depth)-1:0] rd_addr,
    output logic [p_width-1:0]         rd_data
);

    logic [p_width-1:0] mem_r [p_depth];

    // Write the addressed entry; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Circular instruction buffer between fetch and decode with squash flush.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int p_depth        = 4,
    parameter int p_seq_num_bits = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq_val,
    output logic                         enq_rdy,
    input  logic [31:0]                  enq_inst,
    input  logic [31:0]                  enq_pc,
    input  logic [p_seq_num_bits-1:0]    enq_seq_num,
    output logic                         deq_val,
    input  logic                         deq_rdy,
    output logic [31:0]                  deq_inst,
    output logic [31:0]                  deq_pc,
    output logic [p_seq_num_bits-1:0]    deq_seq_num,
    input  logic                         squash_val,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int ptr_w = $clog2(p_depth);
    localparam int cnt_w = $clog2(p_depth+1);

    // Entry layout at this instance's sequence-number width.
    typedef struct packed {
        logic [FDQ_INST_BITS-1:0]  inst;
        logic [FDQ_PC_BITS-1:0]    pc;
        logic [p_seq_num_bits-1:0] seq_num;
    } entry_t;

    logic [ptr_w-1:0] head_r;
    logic [ptr_w-1:0] tail_r;
    logic [cnt_w-1:0] count_r;
    logic             enq_xfer_s;
    logic             deq_xfer_s;
    entry_t           wr_entry_s;
    entry_t           rd_entry_s;

    // Ready depends only on registered occupancy: a full queue refuses an
    // enqueue even if decode drains an entry in the same cycle.
    assign enq_rdy    = (32'(count_r) < 32'(p_depth));
    assign deq_val    = (count_r != {cnt_w{1'b0}}) & ~squash_val;
    assign enq_xfer_s = enq_val & enq_rdy & ~squash_val;
    assign deq_xfer_s = deq_val & deq_rdy;
    assign count      = count_r;

    assign wr_entry_s.inst    = enq_inst;
    assign wr_entry_s.pc      = enq_pc;
    assign wr_entry_s.seq_num = enq_seq_num;

    assign deq_inst    = rd_entry_s.inst;
    assign deq_pc      = rd_entry_s.pc;
    assign deq_seq_num = rd_entry_s.seq_num;

    fdq_storage #(
        .p_depth (p_depth),
        .p_width ($bits(entry_t))
    ) u_storage (
        .clk     (clk),
        .wr_en   (enq_xfer_s),
        .wr_addr (tail_r),
        .wr_data (wr_entry_s),
        .rd_addr (head_r),
        .rd_data (rd_entry_s)
    );

    // Pointer and occupancy update; reset beats squash, squash beats transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {ptr_w{1'b0}};
            tail_r  <= {ptr_w{1'b0}};
            count_r <= {cnt_w{1'b0}};
        end else if (squash_val) begin
            head_r  <= {ptr_w{1'b0}};
            tail_r  <= {ptr_w{1'b0}};
            count_r <= {cnt_w{1'b0}};
        end else begin
            if (enq_xfer_s) begin
                tail_r <= ptr_w'(fdq_ptr_incr(32'(tail_r), 32'(p_depth)));
            end
            if (deq_xfer_s) begin
                head_r <= ptr_w'(fdq_ptr_incr(32'(head_r), 32'(p_depth)));
            end
            case ({enq_xfer_s, deq_xfer_s})
                2'b10:   count_r <= count_r + cnt_w'(1'b1);
                2'b01:   count_r <= count_r - cnt_w'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    fetch_decode_queue_chk #(
        .p_depth (p_depth)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .count    (count_r),
        .deq_xfer (deq_xfer_s)
    );

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue at depth 4 (inst a) and depth 3 (inst b).
module tb_fetch_decode_queue;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  seq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_enq_val = 1'b0, a_deq_rdy = 1'b0, a_squash = 1'b0;
    logic [31:0] a_enq_inst = 32'd0, a_enq_pc = 32'd0;
    logic [4:0]  a_enq_seq = 5'd0;
    logic        a_enq_rdy, a_deq_val;
    logic [31:0] a_deq_inst, a_deq_pc;
    logic [4:0]  a_deq_seq;
    logic [2:0]  a_count;

    logic        b_enq_val = 1'b0, b_deq_rdy = 1'b0, b_squash = 1'b0;
    logic [31:0] b_enq_inst = 32'd0, b_enq_pc = 32'd0;
    logic [4:0]  b_enq_seq = 5'd0;
    logic        b_enq_rdy, b_deq_val;
    logic [31:0] b_deq_inst, b_deq_pc;
    logic [4:0]  b_deq_seq;
    logic [1:0]  b_count;

    fetch_decode_queue #(.p_depth(4), .p_seq_num_bits(5)) dut_a (
        .clk(clk), .rst(rst),
        .enq_val(a_enq_val), .enq_rdy(a_enq_rdy), .enq_inst(a_enq_inst),
        .enq_pc(a_enq_pc), .enq_seq_num(a_enq_seq),
        .deq_val(a_deq_val), .deq_rdy(a_deq_rdy), .deq_inst(a_deq_inst),
        .deq_pc(a_deq_pc), .deq_seq_num(a_deq_seq),
        .squash_val(a_squash), .count(a_count)
    );

    fetch_decode_queue #(.p_depth(3), .p_seq_num_bits(5)) dut_b (
        .clk(clk), .rst(rst),
        .enq_val(b_enq_val), .enq_rdy(b_enq_rdy), .enq_inst(b_enq_inst),
        .enq_pc(b_enq_pc), .enq_seq_num(b_enq_seq),
        .deq_val(b_deq_val), .deq_rdy(b_deq_rdy), .deq_inst(b_deq_inst),
        .deq_pc(b_deq_pc), .deq_seq_num(b_deq_seq),
        .squash_val(b_squash), .count(b_count)
    );

    int   errors = 0;
    int   checks = 0;
    int   ma = 0;
    int   mb = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_0000;
    endfunction

    // Monitor for instance a: every dequeue must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && a_deq_val && a_deq_rdy) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_deq_pc", a_deq_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_deq_pc", a_deq_pc, e.pc);
                check("a_deq_seq", 32'(a_deq_seq), 32'(e.seq));
                check("a_deq_inst", a_deq_inst, e.inst);
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (!rst && b_deq_val && b_deq_rdy) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_deq_pc", b_deq_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_deq_pc", b_deq_pc, e.pc);
                check("b_deq_seq", 32'(b_deq_seq), 32'(e.seq));
                check("b_deq_inst", b_deq_inst, e.inst);
            end
        end
    end

    task automatic step_a(input bit enq, input logic [31:0] pc, input logic [4:0] seq,
                          input bit deq, input bit sq);
        bit enx, dex;
        @(posedge clk); #1;
        a_enq_val = enq; a_enq_pc = pc; a_enq_inst = inst_of(pc); a_enq_seq = seq;
        a_deq_rdy = deq; a_squash = sq;
        @(negedge clk);
        check("a_count", 32'(a_count), 32'(ma));
        check("a_enq_rdy", 32'(a_enq_rdy), 32'(ma < 4));
        check("a_deq_val", 32'(a_deq_val), 32'(ma > 0 && !sq));
        enx = enq && (ma < 4) && !sq;
        dex = deq && (ma > 0) && !sq;
        if (sq) begin
            q_a.delete();
            ma = 0;
        end else begin
            if (enx) q_a.push_back('{inst: inst_of(pc), pc: pc, seq: seq});
            ma = ma + int'(enx) - int'(dex);
        end
    endtask

    task automatic step_b(input bit enq, input logic [31:0] pc, input logic [4:0] seq,
                          input bit deq, input bit sq);
        bit enx, dex;
        @(posedge clk); #1;
        b_enq_val = enq; b_enq_pc = pc; b_enq_inst = inst_of(pc); b_enq_seq = seq;
        b_deq_rdy = deq; b_squash = sq;
        @(negedge clk);
        check("b_count", 32'(b_count), 32'(mb));
        check("b_enq_rdy", 32'(b_enq_rdy), 32'(mb < 3));
        check("b_deq_val", 32'(b_deq_val), 32'(mb > 0 && !sq));
        enx = enq && (mb < 3) && !sq;
        dex = deq && (mb > 0) && !sq;
        if (sq) begin
            q_b.delete();
            mb = 0;
        end else begin
            if (enx) q_b.push_back('{inst: inst_of(pc), pc: pc, seq: seq});
            mb = mb + int'(enx) - int'(dex);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_a_enq_rdy", 32'(a_enq_rdy), 32'd1);
        check("rst_a_deq_val", 32'(a_deq_val), 32'd0);

        // 1: two entries held, then drained in order.
        step_a(1'b1, 32'h200, 5'd1, 1'b0, 1'b0);
        step_a(1'b1, 32'h204, 5'd2, 1'b0, 1'b0);
        step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("t1_count_two_before_drain", 32'(a_count), 32'd2);
        step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        step_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("t1_empty", 32'(a_count), 32'd0);

        // 2: fill to 4, fifth held off even with a dequeue, then accepted.
        for (int i = 0; i < 4; i++) step_a(1'b1, 32'h210 + 32'(4*i), 5'(i + 3), 1'b0, 1'b0);
        step_a(1'b1, 32'h220, 5'd7, 1'b0, 1'b0);
        check("t2_full_count", 32'(a_count), 32'd4);
        check("t2_full_rdy", 32'(a_enq_rdy), 32'd0);
        step_a(1'b1, 32'h220, 5'd7, 1'b1, 1'b0);
        step_a(1'b1, 32'h220, 5'd7, 1'b1, 1'b0);
        check("t2_rdy_after_deq", 32'(a_enq_rdy), 32'd1);
        for (int i = 0; i < 4; i++) step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

        // 3: simultaneous enq/deq at count 2, then 10-entry stream across wrap.
        step_a(1'b1, 32'h230, 5'd8, 1'b0, 1'b0);
        step_a(1'b1, 32'h234, 5'd9, 1'b0, 1'b0);
        step_a(1'b1, 32'h238, 5'd10, 1'b1, 1'b0);
        step_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("t3_count_stays_two", 32'(a_count), 32'd2);
        for (int i = 0; i < 2; i++) step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step_a(1'b1, 32'h200 + 32'(4*i), 5'(i + 16), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

        // 4: squash at count 3 with a concurrent enqueue that must be dropped.
        for (int i = 0; i < 3; i++) step_a(1'b1, 32'h280 + 32'(4*i), 5'(i), 1'b0, 1'b0);
        step_a(1'b1, 32'h300, 5'd30, 1'b1, 1'b1);
        step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("t4_count_after_squash", 32'(a_count), 32'd0);
        step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

        // 5: squash while empty, then enqueue 0x400 right after.
        step_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        step_a(1'b1, 32'h400, 5'd31, 1'b1, 1'b0);
        step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("t5_count_one", 32'(a_count), 32'd1);
        step_a(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("t5_count_zero", 32'(a_count), 32'd0);

        // 6: depth 3, reset together with squash at count 3, then 8-entry wrap run.
        for (int i = 0; i < 3; i++) step_b(1'b1, 32'h480 + 32'(4*i), 5'(i), 1'b0, 1'b0);
        step_b(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("t6_b_full_rdy", 32'(b_enq_rdy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; b_squash = 1'b1; b_enq_val = 1'b0; b_deq_rdy = 1'b0;
        @(negedge clk);
        check("t6_b_deq_val_in_squash", 32'(b_deq_val), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; b_squash = 1'b0;
        q_a.delete(); q_b.delete(); ma = 0; mb = 0;
        @(negedge clk);
        check("t6_b_count_rst", 32'(b_count), 32'd0);
        check("t6_b_enq_rdy_rst", 32'(b_enq_rdy), 32'd1);
        check("t6_b_deq_val_rst", 32'(b_deq_val), 32'd0);
        for (int i = 0; i < 8; i++) step_b(1'b1, 32'h500 + 32'(4*i), 5'(i + 8), (i >= 1), 1'b0);
        for (int i = 0; i < 3; i++) step_b(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

        step_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step_b(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("a_scoreboard_drained", 32'(q_a.size()), 32'd0);
        check("b_scoreboard_drained", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
